// File: rtl/pixel_streamer.sv
// Raster-scan pixel transmitter: tags upstream pixels with (x,y), appends zero
// flush rows so downstream row buffers drain, then pulses frame_done.
module pixel_streamer #(
   parameter int unsigned FRAME_WIDTH  = 640,
   parameter int unsigned FRAME_HEIGHT = 480,
   parameter int unsigned FLUSH_ROWS   = 3,
   parameter int unsigned PIXEL_SIZE   = 24
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [PIXEL_SIZE-1:0] s_data,
   output logic                  en,
   output logic [15:0]           x,
   output logic [15:0]           y,
   output logic [PIXEL_SIZE-1:0] data,
   output logic                  busy,
   output logic                  frame_done
);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      FLUSH,
      DONE
   } state_t;

   localparam logic [15:0] LAST_COL       = 16'(FRAME_WIDTH - 1);
   localparam logic [15:0] LAST_ROW       = 16'(FRAME_HEIGHT - 1);
   localparam logic [15:0] LAST_FLUSH_ROW = 16'(FRAME_HEIGHT + FLUSH_ROWS - 1);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] col;
   logic [15:0] row;
   logic        accept;
   logic        emit;
   logic        col_last;
   logic        last_real;
   logic        last_flush;

   assign s_ready    = (state == STREAM);
   assign busy       = (state == STREAM) || (state == FLUSH);
   assign accept     = s_valid && s_ready;
   assign emit       = accept || (state == FLUSH);
   assign col_last   = (col == LAST_COL);
   assign last_real  = accept && col_last && (row == LAST_ROW);
   assign last_flush = (state == FLUSH) && col_last && (row == LAST_FLUSH_ROW);

   // NOTE: next-state logic assigns its default before the case so no path
   // leaves state_nxt unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = STREAM;
         STREAM:  if (last_real) state_nxt = (FLUSH_ROWS == 0) ? DONE : FLUSH;
         FLUSH:   if (last_flush) state_nxt = DONE;
         // DONE dwells two cycles: the final en cycle, then the frame_done
         // cycle, so a start coinciding with frame_done is still ignored.
         DONE:    if (frame_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: all state uses non-blocking assignments so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         en         <= 1'b0;
         x          <= '0;
         y          <= '0;
         data       <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         en         <= emit;
         frame_done <= (state == DONE) && !frame_done;
         if ((state == IDLE) && start) begin
            col <= '0;
            row <= '0;
         end else if (emit) begin
            x    <= col;
            y    <= row;
            data <= accept ? s_data : '0;
            if (col_last) begin
               col <= '0;
               row <= row + 16'd1;
            end else begin
               col <= col + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pixel_streamer.sv
// Self-checking bench for pixel_streamer: two instances (one flush row, no
// flush rows) driven by directed and random frames against a raster model.
module tb_pixel_streamer;

   localparam int W = 4;
   localparam int H = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic        s_valid = 1'b0;
   logic [23:0] s_data = '0;
   bit          sel = 1'b0;

   logic        start0, start1;
   logic        rdy0, rdy1, en0, en1, busy0, busy1, done0, done1;
   logic [15:0] x0, x1, y0, y1;
   logic [23:0] data0, data1;

   logic [31:0] o_en, o_ready, o_busy, o_done, o_x, o_y, o_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign start0 = start & ~sel;
   assign start1 = start & sel;

   pixel_streamer #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .FLUSH_ROWS(1), .PIXEL_SIZE(24)) u_dut_f1 (
      .clk(clk), .reset_n(reset_n), .start(start0), .s_valid(s_valid), .s_ready(rdy0),
      .s_data(s_data), .en(en0), .x(x0), .y(y0), .data(data0), .busy(busy0), .frame_done(done0)
   );

   pixel_streamer #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .FLUSH_ROWS(0), .PIXEL_SIZE(24)) u_dut_f0 (
      .clk(clk), .reset_n(reset_n), .start(start1), .s_valid(s_valid), .s_ready(rdy1),
      .s_data(s_data), .en(en1), .x(x1), .y(y1), .data(data1), .busy(busy1), .frame_done(done1)
   );

   always_comb begin
      if (sel) begin
         o_en = 32'(en1);   o_ready = 32'(rdy1); o_busy = 32'(busy1); o_done = 32'(done1);
         o_x  = 32'(x1);    o_y     = 32'(y1);   o_data = 32'(data1);
      end else begin
         o_en = 32'(en0);   o_ready = 32'(rdy0); o_busy = 32'(busy0); o_done = 32'(done0);
         o_x  = 32'(x0);    o_y     = 32'(y0);   o_data = 32'(data0);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_en"}, o_en, 0);
      chk({tag, "_ready"}, o_ready, 0);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_done"}, o_done, 0);
      chk({tag, "_x"}, o_x, 0);
      chk({tag, "_y"}, o_y, 0);
      chk({tag, "_data"}, o_data, 0);
   endtask

   // Model: the k-th accepted pixel appears at (k%W, k/W) one cycle after its
   // accept; flush pixel j appears at (j%W, H+j/W) with zero data, back to back.
   task automatic run_frame(input int mode, input bit mid_start, input bit done_start);
      int          fr;
      int          acc;
      int          cyc;
      bit          v;
      logic [23:0] d;
      logic [23:0] hd;
      int          hx, hy;
      fr  = sel ? 0 : 1;
      acc = 0;
      cyc = 0;
      hx  = 0;
      hy  = 0;
      hd  = '0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("stream_ready", o_ready, 1);
      chk("stream_busy", o_busy, 1);
      chk("stream_en_idle", o_en, 0);
      while (acc < W * H) begin
         if (cyc > 200) begin
            chk("accept_timeout", acc, W * H);
            break;
         end
         case (mode)
            0:       v = 1'b1;
            1:       v = (cyc % 3 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         d       = (mode == 0) ? 24'(acc + 1) : 24'($urandom);
         s_valid = v;
         s_data  = d;
         start   = mid_start && (cyc == 3);
         @(posedge clk); #1;
         start = 1'b0;
         chk("en", o_en, int'(v));
         if (v) begin
            chk("x", o_x, acc % W);
            chk("y", o_y, acc / W);
            chk("data", o_data, 32'(d));
            hx = acc % W;
            hy = acc / W;
            hd = d;
            acc++;
         end else if (acc > 0) begin
            chk("hold_x", o_x, hx);
            chk("hold_y", o_y, hy);
            chk("hold_data", o_data, 32'(hd));
         end
         chk("ready", o_ready, (acc < W * H) ? 1 : 0);
         chk("busy", o_busy, ((acc < W * H) || (fr > 0)) ? 1 : 0);
         cyc++;
      end
      for (int j = 0; j < fr * W; j++) begin
         s_valid = 1'($urandom_range(0, 1));
         s_data  = 24'($urandom);
         @(posedge clk); #1;
         chk("fl_en", o_en, 1);
         chk("fl_x", o_x, j % W);
         chk("fl_y", o_y, H + j / W);
         chk("fl_data", o_data, 0);
         chk("fl_ready", o_ready, 0);
         chk("fl_done", o_done, 0);
      end
      @(posedge clk); #1;
      chk("done_pulse", o_done, 1);
      chk("done_en", o_en, 0);
      chk("done_busy", o_busy, 0);
      start = done_start;
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_once", o_done, 0);
      chk("post_busy", o_busy, 0);
      chk("post_ready", o_ready, 0);
      chk("post_en", o_en, 0);
   endtask

   initial begin
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      sel = 1'b1;
      #0 chk_all_zero("reset_f0");
      sel = 1'b0;

      // Idle with s_valid high and no start: nothing moves.
      reset_n = 1'b1;
      s_valid = 1'b1;
      s_data  = 24'hABCDEF;
      repeat (5) begin
         @(posedge clk); #1;
         chk_all_zero("idle");
      end

      run_frame(0, 1'b0, 1'b0);   // full rate, data 1..8
      run_frame(1, 1'b0, 1'b0);   // stall pattern 1,0,0
      run_frame(2, 1'b1, 1'b1);   // random valid, start mid-stream and at frame_done
      run_frame(0, 1'b0, 1'b0);   // start the cycle after frame_done

      sel = 1'b1;
      run_frame(0, 1'b0, 1'b1);
      run_frame(2, 1'b0, 1'b0);
      sel = 1'b0;

      // Reset after five accepts, then a clean restart from (0,0).
      start = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      s_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         s_data = 24'($urandom);
         @(posedge clk); #1;
      end
      chk("pre_rst_en", o_en, 1);
      chk("pre_rst_x", o_x, 0);
      chk("pre_rst_y", o_y, 1);
      #1 reset_n = 1'b0;
      #1 chk_all_zero("async_rst");
      @(posedge clk); #1;
      chk_all_zero("held_rst");
      reset_n = 1'b1;
      run_frame(0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
